// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: four-master round-robin bus arbiter with a tenure quantum.
// A master keeps the bus while it holds its request. After QUANTUM consecutive grant cycles,
// it loses the bus to the next round-robin requester, unless its lock bit is set.
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   m_req[3:0]   level-held bus requests, bit i = master i
//   m_lock[3:0]  bit i high = master i exempt from quantum preemption while it owns the bus
//   m_grant[3:0] registered one-hot grant, zero when idle
//   grant_id     registered index of the granted master, holds last value when idle
//   grant_valid  registered, high iff m_grant is nonzero
//   hold_cnt     registered cycles elapsed in the current tenure
module bus_rr_arbiter #(
  parameter int unsigned QUANTUM = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] m_req,
  input  logic [3:0] m_lock,
  output logic [3:0] m_grant,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic [7:0] hold_cnt
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [7:0] LastCnt = 8'(QUANTUM - 1);

  state_e     r_state;
  logic [3:0] r_grant;
  logic [1:0] r_grant_id;
  logic       r_grant_valid;
  logic [7:0] r_hold_cnt;
  logic [1:0] r_last_id;

  logic [3:0] w_others;
  logic       w_owner_req;
  logic       w_preempt;
  logic [3:0] w_pick_req;
  logic [1:0] w_winner;
  logic       w_start;

  // Search starts one past `last` and wraps around. The loop runs from the farthest slot to the
  // nearest, so the nearest requesting slot is the last one assigned.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    w_others    = m_req & ~r_grant;
    w_owner_req = m_req[r_grant_id];
    w_preempt   = (r_state == StGrant) && w_owner_req && (r_hold_cnt == LastCnt) &&
                  !m_lock[r_grant_id] && (|w_others);
    // When the owner is preempted it must be excluded from the search.
    w_pick_req  = w_preempt ? w_others : m_req;
    w_winner    = rr_pick(w_pick_req, r_last_id);
    w_start     = 1'b0;
    unique case (r_state)
      StIdle:  w_start = |m_req;
      StGrant: w_start = (!w_owner_req && (|m_req)) || w_preempt;
      default: w_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_grant       <= 4'b0000;
      r_grant_id    <= 2'd0;
      r_grant_valid <= 1'b0;
      r_hold_cnt    <= 8'd0;
      r_last_id     <= 2'd3;
    end else if (w_start) begin
      // New tenure, including a zero-gap handover from a previous owner.
      r_state       <= StGrant;
      r_grant       <= 4'b0001 << w_winner;
      r_grant_id    <= w_winner;
      r_grant_valid <= 1'b1;
      r_hold_cnt    <= 8'd0;
      r_last_id     <= w_winner;
    end else if (r_state == StGrant) begin
      if (!w_owner_req) begin
        r_state       <= StIdle;
        r_grant       <= 4'b0000;
        r_grant_valid <= 1'b0;
        r_hold_cnt    <= 8'd0;
      end else begin
        // The owner is not preempted: locked, or nobody is waiting. The count wraps.
        r_hold_cnt <= (r_hold_cnt == LastCnt) ? 8'd0 : r_hold_cnt + 8'd1;
      end
    end
  end

  assign m_grant     = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign hold_cnt    = r_hold_cnt;

endmodule
